div_arbiter: RTL

DIV_ARBITER -- requirements
Module: div_arbiter

---
 rtl/div_arbiter.sv | 129 ++++++++++++
 1 files changed

// File: rtl/div_arbiter.sv
// Two-requester round-robin arbiter in front of a shared 8-bit restoring divider.
// Each done pulse is registered on the edge that leaves DONE, so it lands in the
// following IDLE cycle alongside the already-loaded results.
module div_arbiter (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0,
  input  logic [7:0] a0,
  input  logic [7:0] b0,
  input  logic       req1,
  input  logic [7:0] a1,
  input  logic [7:0] b1,
  output logic       gnt0,
  output logic       gnt1,
  output logic       done0,
  output logic       done1,
  output logic       busy,
  output logic [7:0] quotient,
  output logic [7:0] remainder,
  output logic       div_zero
);

  typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;

  state_t      state, state_nx;
  logic        last_gnt;
  logic        owner;
  logic [7:0]  a_reg;
  logic [7:0]  b_reg;
  logic [7:0]  r_reg;
  logic [7:0]  q_reg;
  logic [2:0]  cnt;

  logic        grant_any;
  logic        pick;
  logic [7:0]  a_sel;
  logic [7:0]  b_sel;
  logic [8:0]  r_shift;
  logic        q_bit;
  logic [7:0]  r_next;

  always_comb begin
    grant_any = req0 | req1;
    // pick = 1 selects requester 1; on contention the one not granted last wins
    pick      = (req0 && req1) ? ~last_gnt : req1;
    a_sel     = pick ? a1 : a0;
    b_sel     = pick ? b1 : b0;
    // the shifted partial remainder keeps its MSB so divisors above 128 compare correctly
    r_shift   = {r_reg, a_reg[7]};
    q_bit     = (r_shift >= {1'b0, b_reg});
    r_next    = q_bit ? 8'(r_shift - {1'b0, b_reg}) : r_shift[7:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (grant_any) state_nx = (b_sel == 8'd0) ? DONE : DIV;
      DIV:     if (cnt == 3'd7) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_gnt  <= 1'b1;
      owner     <= 1'b0;
      a_reg     <= '0;
      b_reg     <= '0;
      r_reg     <= '0;
      q_reg     <= '0;
      cnt       <= '0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
      done0     <= 1'b0;
      done1     <= 1'b0;
    end else begin
      done0 <= 1'b0;
      done1 <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_any) begin
            owner    <= pick;
            last_gnt <= pick;
            a_reg    <= a_sel;
            b_reg    <= b_sel;
            r_reg    <= '0;
            q_reg    <= '0;
            cnt      <= '0;
            if (b_sel == 8'd0) begin
              quotient  <= '0;
              remainder <= '0;
              div_zero  <= 1'b1;
            end
          end
        end
        DIV: begin
          r_reg <= r_next;
          q_reg <= {q_reg[6:0], q_bit};
          a_reg <= {a_reg[6:0], 1'b0};
          cnt   <= cnt + 3'd1;
          if (cnt == 3'd7) begin
            quotient  <= {q_reg[6:0], q_bit};
            remainder <= r_next;
            div_zero  <= 1'b0;
          end
        end
        DONE: begin
          done0 <= ~owner;
          done1 <= owner;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    busy = (state != IDLE);
    gnt0 = busy && !owner;
    gnt1 = busy && owner;
  end

endmodule
